// File: rtl/canvas_pkg.sv
// Shared definitions for the handwriting canvas: geometry, writer state
// encoding and the pixel address map used by both the writer and the
// display read path.
package canvas_pkg;

  localparam int CANVAS_W     = 320;
  localparam int CANVAS_H     = 240;
  localparam int CANVAS_DEPTH = 76800;
  localparam int ADDR_W       = 17;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAW  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  // Linear canvas address; the 11-bit operands let signed brush offsets that
  // have already been range-checked be passed straight through.
  function automatic logic [ADDR_W-1:0] canvas_addr(input logic [10:0] x,
                                                    input logic [10:0] y);
    return ADDR_W'(x) + ADDR_W'(y) * ADDR_W'(CANVAS_W);
  endfunction

endpackage

// File: rtl/canvas_writer_if.sv
// Mouse/clear command inputs and BRAM write-port outputs of the canvas
// writer, bundled as one interface. The writer uses the slave view; the
// environment that drives mouse events and owns the BRAM uses the master view.
interface canvas_writer_if;
  import canvas_pkg::*;

  logic [9:0]        mouse_x;
  logic [9:0]        mouse_y;
  logic              mouse_left;
  logic              mouse_new_event;
  logic              clear_req;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_data;
  logic              busy;
  logic              clear_done;

  modport master (
    output mouse_x, mouse_y, mouse_left, mouse_new_event, clear_req,
    input  wr_en, wr_addr, wr_data, busy, clear_done
  );

  modport slave (
    input  mouse_x, mouse_y, mouse_left, mouse_new_event, clear_req,
    output wr_en, wr_addr, wr_data, busy, clear_done
  );

endinterface

// File: rtl/canvas_writer.sv
// Canvas frame-buffer writer: stamps a square brush around each accepted
// left-button mouse event and sweeps the whole canvas on a clear request.
// All outputs are registered; wr_addr doubles as the clear sweep counter.
module canvas_writer
  import canvas_pkg::*;
#(
  parameter int   BRUSH_R = 1,
  parameter logic INK     = 1'b1
) (
  input logic             clk,
  input logic             rst,
  canvas_writer_if.slave  bus
);

  localparam logic signed [10:0] BR_S = 11'(BRUSH_R);
  localparam logic signed [10:0] CW_S = 11'(CANVAS_W);
  localparam logic signed [10:0] CH_S = 11'(CANVAS_H);
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(CANVAS_DEPTH - 1);

  state_t            state_r;
  logic              wr_en_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic              wr_data_r;
  logic              busy_r;
  logic              clear_done_r;
  logic              clear_pending_r;
  logic [8:0]        cx_r;
  logic [8:0]        cy_r;
  logic signed [10:0] dx_r;
  logic signed [10:0] dy_r;

  logic [8:0]         ev_x_s;
  logic [8:0]         ev_y_s;
  logic               ev_ok_s;
  logic [8:0]         base_x_s;
  logic [8:0]         base_y_s;
  logic signed [10:0] off_dx_s;
  logic signed [10:0] off_dy_s;
  logic signed [10:0] px_s;
  logic signed [10:0] py_s;
  logic               in_bounds_s;
  logic               stamp_done_s;
  logic [ADDR_W-1:0]  stamp_addr_s;

  // Screen-to-canvas mapping of the incoming event and its acceptance test.
  always_comb begin
    ev_x_s  = 9'(bus.mouse_x >> 1);
    ev_y_s  = 9'(bus.mouse_y >> 1);
    ev_ok_s = bus.mouse_new_event && bus.mouse_left &&
              (bus.mouse_x < 10'd640) && (bus.mouse_y < 10'd480);
  end

  // Brush offset to emit on the coming edge: the first offset comes from the
  // live event in IDLE, later ones step dx fastest, then dy.
  always_comb begin
    base_x_s = cx_r;
    base_y_s = cy_r;
    off_dx_s = dx_r;
    off_dy_s = dy_r;
    case (state_r)
      IDLE: begin
        base_x_s = ev_x_s;
        base_y_s = ev_y_s;
        off_dx_s = -BR_S;
        off_dy_s = -BR_S;
      end
      DRAW: begin
        if (dx_r == BR_S) begin
          off_dx_s = -BR_S;
          off_dy_s = dy_r + 11'sd1;
        end else begin
          off_dx_s = dx_r + 11'sd1;
          off_dy_s = dy_r;
        end
      end
      default: begin
        off_dx_s = dx_r;
        off_dy_s = dy_r;
      end
    endcase
    px_s         = $signed({2'b00, base_x_s}) + off_dx_s;
    py_s         = $signed({2'b00, base_y_s}) + off_dy_s;
    in_bounds_s  = (px_s >= 11'sd0) && (px_s < CW_S) &&
                   (py_s >= 11'sd0) && (py_s < CH_S);
    stamp_addr_s = canvas_addr(px_s, py_s);
    stamp_done_s = (dx_r == BR_S) && (dy_r == BR_S);
  end

  // Writer FSM with registered write-port, busy and clear_done outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= IDLE;
      wr_en_r         <= 1'b0;
      wr_addr_r       <= '0;
      wr_data_r       <= 1'b0;
      busy_r          <= 1'b0;
      clear_done_r    <= 1'b0;
      clear_pending_r <= 1'b0;
      cx_r            <= 9'd0;
      cy_r            <= 9'd0;
      dx_r            <= 11'sd0;
      dy_r            <= 11'sd0;
    end else begin
      clear_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.clear_req || clear_pending_r) begin
            state_r         <= CLEAR;
            clear_pending_r <= 1'b0;
            wr_en_r         <= 1'b1;
            wr_addr_r       <= '0;
            wr_data_r       <= ~INK;
            busy_r          <= 1'b1;
          end else if (ev_ok_s) begin
            state_r <= DRAW;
            cx_r    <= ev_x_s;
            cy_r    <= ev_y_s;
            dx_r    <= -BR_S;
            dy_r    <= -BR_S;
            wr_en_r <= in_bounds_s;
            busy_r  <= 1'b1;
            if (in_bounds_s) begin
              wr_addr_r <= stamp_addr_s;
              wr_data_r <= INK;
            end
          end else begin
            wr_en_r <= 1'b0;
            busy_r  <= 1'b0;
          end
        end
        DRAW: begin
          if (bus.clear_req) begin
            clear_pending_r <= 1'b1;
          end
          if (stamp_done_s) begin
            state_r <= IDLE;
            wr_en_r <= 1'b0;
            busy_r  <= 1'b0;
          end else begin
            dx_r    <= off_dx_s;
            dy_r    <= off_dy_s;
            wr_en_r <= in_bounds_s;
            busy_r  <= 1'b1;
            if (in_bounds_s) begin
              wr_addr_r <= stamp_addr_s;
              wr_data_r <= INK;
            end
          end
        end
        CLEAR: begin
          if (wr_addr_r == LAST_ADDR) begin
            state_r      <= IDLE;
            wr_en_r      <= 1'b0;
            busy_r       <= 1'b0;
            clear_done_r <= 1'b1;
          end else begin
            wr_addr_r <= wr_addr_r + 17'd1;
            wr_en_r   <= 1'b1;
            busy_r    <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          wr_en_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wr_en      = wr_en_r;
  assign bus.wr_addr    = wr_addr_r;
  assign bus.wr_data    = wr_data_r;
  assign bus.busy       = busy_r;
  assign bus.clear_done = clear_done_r;

endmodule

// File: tb/tb_canvas_writer.sv
// Scoreboard bench for canvas_writer. A behavioural model turns each cycle's
// stimulus into the expected output of the next cycle and queues it; a
// monitor on the falling edge pops and compares against the DUT.
module tb_canvas_writer;

  typedef struct {
    bit        en;
    bit [16:0] addr;
    bit        data;
    bit        chk_data;
    bit        busy;
    bit        done;
    bit        is_draw;
  } rec_t;

  localparam int R = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  canvas_writer_if cw ();

  canvas_writer #(.BRUSH_R(R), .INK(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (cw)
  );

  always #5 clk = ~clk;

  rec_t      sb[$];
  rec_t      plan[$];
  rec_t      cur;
  bit        pending;
  bit [16:0] last_addr;
  int        n_checks = 0;
  int        n_fail   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic rec_t idle_rec(input bit done);
    rec_t r;
    r = '{en: 1'b0, addr: last_addr, data: 1'b0, chk_data: 1'b0,
          busy: 1'b0, done: done, is_draw: 1'b0};
    return r;
  endfunction

  // Expected stamp: every offset of the square takes one cycle.
  task automatic build_stamp(input int cx, input int cy);
    bit [16:0] hold = last_addr;
    for (int dy = -R; dy <= R; dy++) begin
      for (int dx = -R; dx <= R; dx++) begin
        int px = cx + dx;
        int py = cy + dy;
        rec_t r;
        r.busy = 1'b1; r.is_draw = 1'b1; r.done = 1'b0;
        if (px >= 0 && px < 320 && py >= 0 && py < 240) begin
          hold = 17'(px + 320 * py);
          r.en = 1'b1; r.data = 1'b1; r.chk_data = 1'b1;
        end else begin
          r.en = 1'b0; r.data = 1'b0; r.chk_data = 1'b0;
        end
        r.addr = hold;
        plan.push_back(r);
      end
    end
  endtask

  task automatic build_clear();
    for (int a = 0; a < 76800; a++)
      plan.push_back('{en: 1'b1, addr: 17'(a), data: 1'b0, chk_data: 1'b1,
                       busy: 1'b1, done: 1'b0, is_draw: 1'b0});
  endtask

  // Reference model: decide the next cycle's output from this cycle's inputs.
  task automatic model_decide(input bit r, input bit ev, input bit left,
                              input int x, input int y, input bit clr);
    rec_t nxt;
    if (r) begin
      plan.delete();
      pending   = 1'b0;
      last_addr = 17'd0;
      nxt = '{en: 1'b0, addr: 17'd0, data: 1'b0, chk_data: 1'b1,
              busy: 1'b0, done: 1'b0, is_draw: 1'b0};
    end else if (cur.busy) begin
      if (cur.is_draw && clr) pending = 1'b1;
      if (plan.size() > 0) nxt = plan.pop_front();
      else nxt = idle_rec(!cur.is_draw);
    end else if (clr || pending) begin
      pending = 1'b0;
      build_clear();
      nxt = plan.pop_front();
    end else if (ev && left && x < 640 && y < 480) begin
      build_stamp(x / 2, y / 2);
      nxt = plan.pop_front();
    end else begin
      nxt = idle_rec(1'b0);
    end
    if (nxt.en) last_addr = nxt.addr;
    cur = nxt;
    sb.push_back(nxt);
  endtask

  task automatic cycle(input bit r, input bit ev, input bit left,
                       input int x, input int y, input bit clr);
    rst                = r;
    cw.mouse_new_event = ev;
    cw.mouse_left      = left;
    cw.mouse_x         = 10'(x);
    cw.mouse_y         = 10'(y);
    cw.clear_req       = clr;
    model_decide(r, ev, left, x, y, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic event_at(input int x, input int y, input bit left);
    cycle(1'b0, 1'b1, left, x, y, 1'b0);
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      rec_t e;
      e = sb.pop_front();
      chk("wr_en", int'(cw.wr_en), int'(e.en));
      chk("busy", int'(cw.busy), int'(e.busy));
      chk("clear_done", int'(cw.clear_done), int'(e.done));
      chk("wr_addr", int'(cw.wr_addr), int'(e.addr));
      if (e.chk_data) chk("wr_data", int'(cw.wr_data), int'(e.data));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    cur = '{en: 1'b0, addr: 17'd0, data: 1'b0, chk_data: 1'b0,
            busy: 1'b0, done: 1'b0, is_draw: 1'b0};
    pending   = 1'b0;
    last_addr = 17'd0;
    cw.mouse_x = 10'd0; cw.mouse_y = 10'd0; cw.mouse_left = 1'b0;
    cw.mouse_new_event = 1'b0; cw.clear_req = 1'b0;

    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    idle(2);

    // Centre stamp, with a second event while busy that must be dropped.
    event_at(100, 50, 1'b1);
    event_at(200, 200, 1'b1);
    idle(12);

    // Corner stamps clipped by the canvas edges.
    event_at(0, 0, 1'b1);
    idle(12);
    event_at(639, 479, 1'b1);
    idle(12);

    // Rejected events: button up, x out of range, y out of range.
    event_at(50, 50, 1'b0);
    event_at(700, 100, 1'b1);
    event_at(100, 480, 1'b1);
    idle(5);

    // Clear and draw in the same cycle; clear wins. Stray requests mid-clear.
    cycle(1'b0, 1'b1, 1'b1, 300, 300, 1'b1);
    n = 0;
    while (!cur.done && n < 80000) begin
      if (n == 100) cycle(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
      else if (n == 200) event_at(400, 300, 1'b1);
      else idle(1);
      n++;
    end
    if (n >= 80000) chk("clear_bound", n, 79999);
    idle(3);

    // Clear requested in cycle 3 of a stamp: pending, then reset mid-clear.
    event_at(320, 240, 1'b1);
    idle(2);
    cycle(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    n = 0;
    while (!(cur.en && !cur.is_draw && cur.addr == 17'd1000) && n < 2000) begin
      idle(1);
      n++;
    end
    if (n >= 2000) chk("reset_bound", n, 1999);
    cycle(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    idle(10);

    // Randomized events, including ones that land while busy.
    for (int i = 0; i < 400; i++)
      cycle(1'b0, $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0,
            int'($urandom_range(0, 700)), int'($urandom_range(0, 520)), 1'b0);
    idle(12);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
